// File: rtl/out_port_seg_ctrl.sv
// Output-port display controller: converts a written word into two BCD
// digits with a serial restoring divide-by-10, saturating the display at 99.
module out_port_seg_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             pend,
    output logic             done,
    output logic [3:0]       digit_ten,
    output logic [3:0]       digit_one,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] pend_buf_q, pend_buf_d;
    logic [3:0]       rem_q, rem_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       one_q, one_d;
    logic             ovf_q, ovf_d;

    logic [4:0]       r_shift;
    logic             q_bit;

    // Next-state logic: the dividend register shifts quotient bits in at the LSB, so it holds the quotient once the divide finishes.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        pend_buf_d = pend_buf_q;
        rem_d      = rem_q;
        count_d    = count_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        ten_d      = ten_q;
        one_d      = one_q;
        ovf_d      = ovf_q;

        r_shift = {rem_q, dividend_q[WIDTH-1]};
        q_bit   = (r_shift >= 5'd10);

        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    dividend_d = data_in;
                    rem_d      = 4'd0;
                    count_d    = '0;
                    state_d    = DIV;
                end
            end
            DIV: begin
                dividend_d = {dividend_q[WIDTH-2:0], q_bit};
                rem_d      = q_bit ? (r_shift[3:0] - 4'd10) : r_shift[3:0];
                count_d    = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = LATCH;
                end
                if (wr_en) begin
                    pend_buf_d = data_in;
                    pend_d     = 1'b1;
                end
            end
            LATCH: begin
                done_d = 1'b1;
                if (dividend_q > WIDTH'(9)) begin
                    ten_d = 4'd9;
                    one_d = 4'd9;
                    ovf_d = 1'b1;
                end else begin
                    ten_d = dividend_q[3:0];
                    one_d = rem_q;
                    ovf_d = 1'b0;
                end
                rem_d   = 4'd0;
                count_d = '0;
                pend_d  = 1'b0;
                if (wr_en) begin
                    dividend_d = data_in;
                    state_d    = DIV;
                end else if (pend_q) begin
                    dividend_d = pend_buf_q;
                    state_d    = DIV;
                end else begin
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            pend_buf_q <= '0;
            rem_q      <= 4'd0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            ten_q      <= 4'd0;
            one_q      <= 4'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            pend_buf_q <= pend_buf_d;
            rem_q      <= rem_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign pend      = pend_q;
    assign done      = done_q;
    assign digit_ten = ten_q;
    assign digit_one = one_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_out_port_seg_ctrl.sv
// Testbench for out_port_seg_ctrl: directed scenarios plus random writes,
// with a transaction-level model feeding a scoreboard of expected displays.
module tb_out_port_seg_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         busy, pend, done, ovf;
    logic [3:0]   digit_ten, digit_one;

    out_port_seg_ctrl #(.WIDTH(W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .busy      (busy),
        .pend      (pend),
        .done      (done),
        .digit_ten (digit_ten),
        .digit_one (digit_one),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ten;
        int one;
        int ovf;
        int due;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    // Model state: one conversion in flight plus a one-deep buffer.
    bit           m_active = 0;
    int           m_left = 0;
    logic [W-1:0] m_val = '0;
    bit           m_pend = 0;
    logic [W-1:0] m_pend_val = '0;

    int           last_ten = 0;
    int           last_one = 0;
    int           last_ovf = 0;
    bit           prev_done = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t make_exp(input logic [W-1:0] v, input int due);
        exp_t e;
        logic [W-1:0] q;
        q = v / 10;
        if (q > 9) begin
            e.ten = 9;
            e.one = 9;
            e.ovf = 1;
        end else begin
            e.ten = int'(q);
            e.one = int'(v % 10);
            e.ovf = 0;
        end
        e.due = due;
        return e;
    endfunction

    // A conversion started on an edge completes its display update W+1 edges later.
    task automatic model_edge(input bit w, input logic [W-1:0] d);
        cyc++;
        if (!m_active) begin
            if (w) begin
                m_active = 1;
                m_left   = W + 1;
                m_val    = d;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                exp_q.push_back(make_exp(m_val, cyc));
                if (w) begin
                    m_val  = d;
                    m_left = W + 1;
                    m_pend = 0;
                end else if (m_pend) begin
                    m_val  = m_pend_val;
                    m_left = W + 1;
                    m_pend = 0;
                end else begin
                    m_active = 0;
                end
            end else if (w) begin
                m_pend     = 1;
                m_pend_val = d;
            end
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        exp_q.delete();
        last_ten = 0;
        last_one = 0;
        last_ovf = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, check status half a cycle later.
    task automatic applyStimulus(input bit w, input logic [W-1:0] d);
        wr_en   = w;
        data_in = d;
        @(posedge clock);
        model_edge(w, d);
        @(negedge clock);
        check("busy", int'(busy), int'(m_active));
        check("pend", int'(pend), int'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (m_active || exp_q.size() != 0); i++) applyStimulus(1'b0, '0);
        check("drain_timeout", int'(m_active || exp_q.size() != 0), 0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pend"}, int'(pend), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ten"}, int'(digit_ten), 0);
        check({tag, "_one"}, int'(digit_one), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
    endtask

    // Monitor: pop and compare on every done pulse, otherwise outputs must hold.
    always @(negedge clock) begin
        if (resetn) begin
            if (done) begin
                check("done_twice", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("digit_ten", int'(digit_ten), e.ten);
                    check("digit_one", int'(digit_one), e.one);
                    check("ovf", int'(ovf), e.ovf);
                    last_ten = e.ten;
                    last_one = e.one;
                    last_ovf = e.ovf;
                end
            end else begin
                check("hold_ten", int'(digit_ten), last_ten);
                check("hold_one", int'(digit_one), last_one);
                check("hold_ovf", int'(ovf), last_ovf);
            end
        end
        prev_done = done;
    end

    initial begin
        #12;
        checkOutput("reset");
        @(negedge clock);
        resetn = 1'b1;

        applyStimulus(1'b1, 32'd47);
        drain();
        applyStimulus(1'b1, 32'd0);
        drain();
        applyStimulus(1'b1, 32'd99);
        drain();
        applyStimulus(1'b1, 32'd100);
        drain();
        applyStimulus(1'b1, 32'hFFFF_FFFF);
        drain();

        applyStimulus(1'b1, 32'd12);
        idle(5);
        applyStimulus(1'b1, 32'd35);
        idle(3);
        applyStimulus(1'b1, 32'd58);
        drain();

        applyStimulus(1'b1, 32'd21);
        idle(W);
        applyStimulus(1'b1, 32'd86);
        drain();

        applyStimulus(1'b1, 32'd63);
        idle(10);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("mid_reset");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        #2;
        resetn = 1'b1;
        @(negedge clock);
        applyStimulus(1'b1, 32'd5);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] v;
            v = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 120)) : W'($urandom);
            applyStimulus($urandom_range(0, 7) == 0, v);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
